program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the maximum number of 32-bit words loadable.
REQ-002 The block SHALL have parameter ADDR_W, default 64, giving the imem_addr width, matching the PC width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 The block SHALL have port rx_valid, input, 1, meaning an incoming byte is present on rx_data.
REQ-006 The block SHALL have port rx_data, input, 8, the incoming byte.
REQ-007 The block SHALL have port rx_ready, output, 1, meaning the loader can accept a byte this cycle.
REQ-008 The block SHALL have port imem_we, output, 1, a one-cycle write strobe to instruction memory.
REQ-009 The block SHALL have port imem_addr, output, ADDR_W, the byte address of the word being written.
REQ-010 The block SHALL have port imem_data, output, 32, the assembled instruction word.
REQ-011 The block SHALL have port cpu_run, output, 1, the enable released to the PC/register file once the load is complete.
REQ-012 The block SHALL have port busy, output, 1, high in states LEN, DATA and WRITE.
REQ-013 The block SHALL have port err, output, 1, high in state ERR.

Function
REQ-014 A byte SHALL transfer only in a cycle where rx_valid and rx_ready are both 1; rx_data is otherwise ignored.
REQ-015 The stream format SHALL be: a 16-bit word count N, low byte first, then N words of 4 bytes each, least-significant byte first.
REQ-016 The FSM SHALL have exactly the states LEN, DATA, WRITE, DONE and ERR, with LEN entered out of reset.
REQ-017 In LEN, rx_ready SHALL be 1; after the second length byte is accepted, the next state SHALL be ERR if N==0 or N>DEPTH, otherwise DATA.
REQ-018 In DATA, rx_ready SHALL be 1; a 2-bit byte counter SHALL increment per accepted byte, and the fourth byte SHALL move the FSM to WRITE.
REQ-019 In WRITE, rx_ready SHALL be 0 and imem_we SHALL be 1 for exactly one cycle, with imem_addr = 4*word_index and imem_data = the assembled word.
REQ-020 After WRITE, word_index SHALL increment; the FSM SHALL go to DONE if the new word_index == N, otherwise back to DATA.
REQ-021 Latency SHALL be fixed: imem_we is asserted in the cycle after the 4th byte is accepted, and cpu_run rises in the cycle after the last imem_we.
REQ-022 In DONE, cpu_run SHALL be 1 and rx_ready 0; the FSM SHALL remain in DONE until reset, and rx_valid is ignored.
REQ-023 In ERR, err SHALL be 1, and rx_ready, cpu_run and imem_we SHALL be 0; the FSM SHALL remain in ERR until reset.
REQ-024 N == DEPTH SHALL be accepted, with the last write at address 4*(DEPTH-1); N == DEPTH+1 SHALL go to ERR with no write.
REQ-025 imem_addr and imem_data SHALL be held stable outside WRITE; their values there are don't-care but must not toggle imem_we.

Reset
REQ-026 When rst_n=0 at a clock edge, the FSM SHALL go to LEN, all counters SHALL clear to 0, and rx_ready=0 during reset.
REQ-027 During reset, imem_we, cpu_run, busy and err SHALL be 0, and imem_addr and imem_data SHALL be 0.
REQ-028 Reset mid-load SHALL abandon the partial word and count; words already written stay in memory and the next stream restarts at address 0.

Structure
REQ-029 The state encoding, the length-field width (16) and the bytes-per-word constant (4) SHALL live in a shared package, loader_pkg.
REQ-030 Byte-to-word assembly (shift register plus byte counter) SHALL be one sub-module, byte_packer; the FSM and address counter remain in program_loader.

Verification
REQ-031 Single word: bytes 01 00 93 00 50 00 -> one imem_we with addr 0, data 0x00500093; cpu_run=1 one cycle later; err=0.
REQ-032 Three words, with rx_valid dropped for 2 cycles between bytes -> writes at addrs 0, 4 and 8 with correct data; no extra strobes; cpu_run follows.
REQ-033 Length 00 00 -> err=1 after the second byte; rx_ready=0; no imem_we; further bytes are ignored.
REQ-034 Length 41 00 (65, with DEPTH=64) -> ERR with no write; length 40 00 with 64 words -> last write at addr 0xFC, then DONE.
REQ-035 rx_valid held high through WRITE -> byte not consumed in WRITE (rx_ready=0), and is accepted the following cycle.
REQ-036 rst_n pulsed low after 2 data bytes -> all outputs 0; the new stream 01 00 13 00 00 00 writes 0x00000013 at addr 0.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: state encoding, stream field widths
// and the length-field legality check.
package loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  // A stream announcing zero words or more than the memory holds is rejected.
  function automatic logic len_invalid(input logic [LEN_W-1:0] n, input int depth);
    return (n == '0) || (int'(n) > depth);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader,
// plus its run/status outputs. The master side feeds bytes and observes.
interface program_loader_if import loader_pkg::*; #(
  parameter int ADDR_W = 64
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_data;
  logic              cpu_run;
  logic              busy;
  logic              err;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_data, cpu_run, busy, err
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_data, cpu_run, busy, err
  );

endinterface

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into words; flags the byte that completes a word
// and presents the completed word combinationally alongside it.
module byte_packer import loader_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic              word_done,
  output logic [WORD_W-1:0] word_next
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;

  // Right shift so the first byte received ends up in the least-significant lane.
  always_comb begin
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    word_next = {byte_in, shreg_q[WORD_W-1:8]};
    word_done = accept && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
    if (accept) begin
      cnt_d   = cnt_q + 1'b1;
      shreg_d = word_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes each assembled word
// to instruction memory, then releases the CPU (or parks in ERR on a bad length).
module program_loader import loader_pkg::*; #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 64
) (
  input logic             clk,
  input logic             rst_n,
  program_loader_if.slave bus
);

  state_e            state_q, state_d;
  logic              len_byte_q, len_byte_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;

  logic              pack_accept;
  logic              word_done;
  logic [WORD_W-1:0] word_next;
  logic [LEN_W-1:0]  n_rx;

  assign n_rx        = {bus.rx_data, len_lo_q};
  assign pack_accept = rst_n && bus.rx_valid && (state_q == ST_DATA);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (pack_accept),
    .byte_in   (bus.rx_data),
    .word_done (word_done),
    .word_next (word_next)
  );

  always_comb begin
    state_d    = state_q;
    len_byte_d = len_byte_q;
    len_lo_d   = len_lo_q;
    n_d        = n_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    unique case (state_q)
      ST_LEN: begin
        if (bus.rx_valid) begin
          if (!len_byte_q) begin
            len_lo_d   = bus.rx_data;
            len_byte_d = 1'b1;
          end else begin
            n_d        = n_rx;
            len_byte_d = 1'b0;
            state_d    = len_invalid(n_rx, DEPTH) ? ST_ERR : ST_DATA;
          end
        end
      end
      // Address and data are captured only here, so they stay put outside WRITE.
      ST_DATA: begin
        if (word_done) begin
          addr_d  = ADDR_W'({idx_q, BCNT_W'(0)});
          data_d  = word_next;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_d == n_q) ? ST_DONE : ST_DATA;
      end
      ST_DONE: ;
      ST_ERR:  ;
      default: state_d = ST_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_LEN;
      len_byte_q <= 1'b0;
      n_q        <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_byte_q <= len_byte_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    len_lo_q <= len_lo_d;
  end

  // Outputs are forced low while rst_n is held, including before the first edge.
  assign bus.rx_ready  = rst_n && ((state_q == ST_LEN) || (state_q == ST_DATA));
  assign bus.imem_we   = rst_n && (state_q == ST_WRITE);
  assign bus.imem_addr = rst_n ? addr_q : '0;
  assign bus.imem_data = rst_n ? data_q : '0;
  assign bus.cpu_run   = rst_n && (state_q == ST_DONE);
  assign bus.busy      = rst_n && ((state_q == ST_LEN) || (state_q == ST_DATA) ||
                                   (state_q == ST_WRITE));
  assign bus.err       = rst_n && (state_q == ST_ERR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random streams compared
// against a stream-level model of expected writes, latencies and final status.
module tb_program_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle: byte acceptances, write strobes, status rises.
  int          acc_cyc[$];
  int          we_cyc[$];
  logic [63:0] we_addr[$];
  logic [31:0] we_data[$];
  int          err_rise[$];
  int          run_rise[$];
  logic        err_prev = 1'b0;
  logic        run_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) acc_cyc.push_back(cyc);
    if (bus.imem_we) begin
      we_cyc.push_back(cyc);
      we_addr.push_back(bus.imem_addr);
      we_data.push_back(bus.imem_data);
    end
    if (bus.err && !err_prev)     err_rise.push_back(cyc);
    if (bus.cpu_run && !run_prev) run_rise.push_back(cyc);
    err_prev = bus.err;
    run_prev = bus.cpu_run;
  end

  logic [7:0] stream[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string name);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({name, "_rst_ready"}, bus.rx_ready, 0);
    chk({name, "_rst_we"},    bus.imem_we, 0);
    chk({name, "_rst_run"},   bus.cpu_run, 0);
    chk({name, "_rst_busy"},  bus.busy, 0);
    chk({name, "_rst_err"},   bus.err, 0);
    chk({name, "_rst_addr"},  bus.imem_addr, 0);
    chk({name, "_rst_data"},  bus.imem_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk({name, "_len_ready"}, bus.rx_ready, 1);
    chk({name, "_len_busy"},  bus.busy, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, output bit ok);
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    bus.rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 32 && !ok; t++) begin
      @(negedge clk);
      if (bus.rx_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic make_stream(input int n_field, input int nwords);
    stream.delete();
    stream.push_back(8'(n_field));
    stream.push_back(8'(n_field >> 8));
    for (int i = 0; i < 4 * nwords; i++) stream.push_back(8'($urandom));
  endtask

  // Model: the stream itself defines every expected write, address and cycle.
  task automatic run_stream(input string name, input int gap_max);
    int a0, w0, e0, r0, n, nsend, wb;
    bit bad_len, ok;
    logic [31:0] exp_word;
    a0 = acc_cyc.size();
    w0 = we_cyc.size();
    e0 = err_rise.size();
    r0 = run_rise.size();
    n       = int'({stream[1], stream[0]});
    bad_len = (n == 0) || (n > DEPTH);
    nsend   = bad_len ? 2 : 2 + 4 * n;
    ok = 1'b1;
    for (int i = 0; i < nsend && ok; i++) send_byte(stream[i], gap_max, ok);
    chk({name, "_no_timeout"}, ok, 1);
    // Bytes offered after the end of the stream must never be taken.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'($urandom);
    repeat (6) @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_accepted"}, acc_cyc.size() - a0, nsend);
    if (bad_len) begin
      chk({name, "_we_count"}, we_cyc.size() - w0, 0);
      chk({name, "_err_rises"}, err_rise.size() - e0, 1);
      chk({name, "_run_rises"}, run_rise.size() - r0, 0);
      if (err_rise.size() > e0 && acc_cyc.size() >= a0 + 2)
        chk({name, "_err_latency"}, err_rise[e0], acc_cyc[a0 + 1] + 1);
      @(negedge clk);
      chk({name, "_err_level"}, bus.err, 1);
      chk({name, "_err_ready"}, bus.rx_ready, 0);
      chk({name, "_err_run"},   bus.cpu_run, 0);
    end else begin
      chk({name, "_we_count"}, we_cyc.size() - w0, n);
      chk({name, "_run_rises"}, run_rise.size() - r0, 1);
      chk({name, "_err_rises"}, err_rise.size() - e0, 0);
      if (we_cyc.size() - w0 == n && acc_cyc.size() - a0 == nsend) begin
        for (int k = 0; k < n; k++) begin
          wb = a0 + 2 + 4 * k;
          exp_word = {stream[2 + 4*k + 3], stream[2 + 4*k + 2],
                      stream[2 + 4*k + 1], stream[2 + 4*k]};
          chk($sformatf("%s_addr%0d", name, k), we_addr[w0 + k], 64'(4 * k));
          chk($sformatf("%s_data%0d", name, k), we_data[w0 + k], 64'(exp_word));
          chk($sformatf("%s_we_lat%0d", name, k), we_cyc[w0 + k], acc_cyc[wb + 3] + 1);
          if (gap_max == 0 && k < n - 1)
            chk($sformatf("%s_hold%0d", name, k), acc_cyc[wb + 4], acc_cyc[wb + 3] + 2);
        end
        if (run_rise.size() > r0)
          chk({name, "_run_latency"}, run_rise[r0], we_cyc[w0 + n - 1] + 1);
      end
      @(negedge clk);
      chk({name, "_done_run"},   bus.cpu_run, 1);
      chk({name, "_done_busy"},  bus.busy, 0);
      chk({name, "_done_ready"}, bus.rx_ready, 0);
      chk({name, "_done_err"},   bus.err, 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int pick, n_field;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    do_reset("single");
    stream = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    run_stream("single", 0);

    do_reset("three");
    make_stream(3, 3);
    run_stream("three", 2);

    do_reset("zero");
    stream = '{8'h00, 8'h00};
    run_stream("zero", 1);

    do_reset("over");
    make_stream(DEPTH + 1, 0);
    run_stream("over", 0);

    do_reset("full");
    make_stream(DEPTH, DEPTH);
    run_stream("full", 0);

    // Abandon a partial word, then a fresh stream must start clean at address 0.
    do_reset("midrst");
    stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    ok = 1'b1;
    for (int i = 0; i < 4 && ok; i++) send_byte(stream[i], 0, ok);
    chk("midrst_partial_sent", ok, 1);
    do_reset("midrst2");
    stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    run_stream("midrst_new", 1);

    for (int r = 0; r < 12; r++) begin
      pick = int'($urandom_range(9, 0));
      if (pick == 0)      n_field = 0;
      else if (pick == 1) n_field = int'($urandom_range(65535, DEPTH + 1));
      else                n_field = int'($urandom_range(6, 1));
      do_reset($sformatf("rnd%0d", r));
      make_stream(n_field, (n_field >= 1 && n_field <= DEPTH) ? n_field : 0);
      run_stream($sformatf("rnd%0d", r), int'($urandom_range(3, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
